// File: rtl/cmos_schmitt_hex_pkg.sv
// cmos_schmitt_pkg: default integrator parameters and channel count for the hex Schmitt filter
package cmos_schmitt_pkg;
    localparam int CNT_W_DEF = 4;
    localparam int HI_TH_DEF = 12;
    localparam int LO_TH_DEF = 3;
    localparam int N_CH      = 6;
endpackage

// File: rtl/cmos_schmitt_hex_channel.sv
// schmitt_channel: synchronizer, saturating integrator and hysteresis state with edge pulses
module schmitt_channel
    import cmos_schmitt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int HI_TH = HI_TH_DEF,
    parameter int LO_TH = LO_TH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic din,
    output logic state,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] HI = CNT_W'(HI_TH);
    localparam logic [CNT_W-1:0] LO = CNT_W'(LO_TH);

    if (LO_TH >= HI_TH || HI_TH > (1 << CNT_W) - 1) begin : g_bad_th
        $error("schmitt_channel: thresholds must satisfy LO_TH < HI_TH <= 2^CNT_W-1");
    end

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             state_nx;

    // saturating integrator step and hysteresis decision for the next ce edge
    always_comb begin
        cnt_nx   = sync[1] ? (&cnt ? cnt : cnt + 1'b1) : (cnt == '0 ? cnt : cnt - 1'b1);
        state_nx = state ? (cnt_nx > LO) : (cnt_nx >= HI);
    end

    // synchronizer runs every cycle; integrator, state and pulses only move on ce
    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= '0;
            cnt   <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], din};
            rise <= ce & ~state & state_nx;
            fall <= ce & state & ~state_nx;
            if (ce) begin
                cnt   <= cnt_nx;
                state <= state_nx;
            end
        end
    end
endmodule

// File: rtl/cmos_schmitt_hex.sv
// cmos_schmitt_hex: six independent hysteresis-filtered channels, inverted and buffered outputs
module cmos_schmitt_hex
    import cmos_schmitt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int HI_TH = HI_TH_DEF,
    parameter int LO_TH = LO_TH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       in1,
    input  logic       in2,
    input  logic       in3,
    input  logic       in4,
    input  logic       in5,
    input  logic       in6,
    output logic       out1,
    output logic       out2,
    output logic       out3,
    output logic       out4,
    output logic       out5,
    output logic       out6,
    output logic [5:0] buf_out,
    output logic [5:0] rise,
    output logic [5:0] fall
);
    logic [N_CH-1:0] din;

    assign din = {in6, in5, in4, in3, in2, in1};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        schmitt_channel #(
            .CNT_W(CNT_W),
            .HI_TH(HI_TH),
            .LO_TH(LO_TH)
        ) u_ch (
            .clk  (clk),
            .reset(reset),
            .ce   (ce),
            .din  (din[i]),
            .state(buf_out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign {out6, out5, out4, out3, out2, out1} = ~buf_out;
endmodule

// File: tb/tb_cmos_schmitt_hex.sv
// tb_cmos_schmitt_hex: directed and model-based checks of the hex Schmitt filter
module tb_cmos_schmitt_hex;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic [5:0] iv = 6'h00;
    logic       out1, out2, out3, out4, out5, out6;
    logic [5:0] buf_out, rise, fall, ov;
    int         checks = 0;
    int         errors = 0;

    assign ov = {out6, out5, out4, out3, out2, out1};

    always #5 clk = ~clk;

    cmos_schmitt_hex dut (
        .clk(clk), .reset(reset), .ce(ce),
        .in1(iv[0]), .in2(iv[1]), .in3(iv[2]), .in4(iv[3]), .in5(iv[4]), .in6(iv[5]),
        .out1(out1), .out2(out2), .out3(out3), .out4(out4), .out5(out5), .out6(out6),
        .buf_out(buf_out), .rise(rise), .fall(fall)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; ce = 1'b1; iv = 6'h3F;
        tick; tick;
        checks++; if (buf_out !== 6'h00) begin errors++; $display("FAIL reset_buf: got %h want 00", buf_out); end
        checks++; if (ov !== 6'h3F) begin errors++; $display("FAIL reset_out: got %h want 3f", ov); end
        checks++; if (rise !== 6'h00) begin errors++; $display("FAIL reset_rise: got %h want 00", rise); end
        checks++; if (fall !== 6'h00) begin errors++; $display("FAIL reset_fall: got %h want 00", fall); end
        ce = 1'b0; tick;
        checks++; if (buf_out !== 6'h00) begin errors++; $display("FAIL reset_ce0_buf: got %h want 00", buf_out); end
        reset = 1'b0; iv = 6'h00;
        tick; tick; tick;
        checks++; if (buf_out !== 6'h00 || ov !== 6'h3F) begin errors++; $display("FAIL reset_idle: buf %h out %h want 00/3f", buf_out, ov); end
    endtask

    task automatic test_all_rise;
        ce = 1'b1; iv = 6'h3F;
        for (int j = 1; j <= 13; j++) begin
            tick;
            checks++;
            if (ov !== 6'h3F || rise !== 6'h00) begin errors++; $display("FAIL all_rise_early[%0d]: out %h rise %h want 3f/00", j, ov, rise); end
        end
        tick;
        checks++; if (ov !== 6'h00) begin errors++; $display("FAIL all_rise_out: got %h want 00", ov); end
        checks++; if (rise !== 6'h3F || fall !== 6'h00) begin errors++; $display("FAIL all_rise_pulse: rise %h fall %h want 3f/00", rise, fall); end
        tick;
        checks++; if (rise !== 6'h00 || buf_out !== 6'h3F) begin errors++; $display("FAIL all_rise_after: rise %h buf %h want 00/3f", rise, buf_out); end
    endtask

    task automatic test_glitch;
        logic [5:0] eb, ef;
        repeat (5) tick;
        iv[2] = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            tick;
            if (i == 11) iv[2] = 1'b1;
            checks++;
            if (buf_out !== 6'h3F || fall !== 6'h00 || rise !== 6'h00) begin
                errors++; $display("FAIL glitch11[%0d]: buf %h fall %h rise %h want 3f/00/00", i, buf_out, fall, rise);
            end
        end
        iv[2] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (i == 12) iv[2] = 1'b1;
            eb = (i >= 14) ? 6'h3B : 6'h3F;
            ef = (i == 14) ? 6'h04 : 6'h00;
            checks++;
            if (buf_out !== eb || fall !== ef || rise !== 6'h00 || out3 !== ~eb[2]) begin
                errors++; $display("FAIL glitch12[%0d]: buf %h fall %h rise %h out3 %b want %h/%h/00/%b", i, buf_out, fall, rise, out3, eb, ef, ~eb[2]);
            end
        end
    endtask

    task automatic test_ce_slow;
        logic [5:0] e;
        reset = 1'b1; tick;
        reset = 1'b0; ce = 1'b0; iv = 6'h02;
        tick; tick;
        for (int p = 1; p <= 12; p++) begin
            e = (p == 12) ? 6'h02 : 6'h00;
            ce = 1'b1; tick;
            checks++;
            if (rise !== e || buf_out !== e) begin errors++; $display("FAIL ce_slow_pulse[%0d]: rise %h buf %h want %h/%h", p, rise, buf_out, e, e); end
            ce = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick;
                checks++;
                if (rise !== 6'h00 || buf_out !== e) begin errors++; $display("FAIL ce_slow_hold[%0d.%0d]: rise %h buf %h want 00/%h", p, k, rise, buf_out, e); end
            end
        end
    endtask

    task automatic test_saturate;
        logic [5:0] eb, ep;
        ce = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick;
            checks++;
            if (rise !== 6'h00 || fall !== 6'h00 || buf_out !== 6'h02) begin errors++; $display("FAIL sat_hi[%0d]: rise %h fall %h buf %h want 00/00/02", i, rise, fall, buf_out); end
        end
        iv = 6'h00;
        for (int i = 1; i <= 16; i++) begin
            tick;
            ep = (i == 14) ? 6'h02 : 6'h00;
            eb = (i < 14) ? 6'h02 : 6'h00;
            checks++;
            if (fall !== ep || buf_out !== eb || rise !== 6'h00) begin errors++; $display("FAIL sat_fall[%0d]: fall %h buf %h rise %h want %h/%h/00", i, fall, buf_out, rise, ep, eb); end
        end
        for (int i = 1; i <= 40; i++) begin
            tick;
            checks++;
            if (rise !== 6'h00 || fall !== 6'h00 || buf_out !== 6'h00) begin errors++; $display("FAIL sat_lo[%0d]: rise %h fall %h buf %h want 00/00/00", i, rise, fall, buf_out); end
        end
        iv = 6'h02;
        for (int i = 1; i <= 14; i++) begin
            tick;
            ep = (i == 14) ? 6'h02 : 6'h00;
            checks++;
            if (rise !== ep || buf_out !== ep) begin errors++; $display("FAIL sat_rise[%0d]: rise %h buf %h want %h/%h", i, rise, buf_out, ep, ep); end
        end
    endtask

    task automatic test_reset_mid;
        logic [5:0] ep;
        repeat (5) tick;
        iv = 6'h00;
        for (int i = 1; i <= 7; i++) begin
            tick;
            checks++;
            if (buf_out !== 6'h02 || fall !== 6'h00) begin errors++; $display("FAIL mid_decay[%0d]: buf %h fall %h want 02/00", i, buf_out, fall); end
        end
        reset = 1'b1;
        tick;
        checks++; if (buf_out !== 6'h00 || ov !== 6'h3F) begin errors++; $display("FAIL mid_reset_state: buf %h out %h want 00/3f", buf_out, ov); end
        checks++; if (fall !== 6'h00 || rise !== 6'h00) begin errors++; $display("FAIL mid_reset_pulse: fall %h rise %h want 00/00", fall, rise); end
        reset = 1'b0; iv = 6'h3F;
        for (int i = 1; i <= 14; i++) begin
            tick;
            ep = (i == 14) ? 6'h3F : 6'h00;
            checks++;
            if (rise !== ep || buf_out !== ep) begin errors++; $display("FAIL mid_restart[%0d]: rise %h buf %h want %h/%h", i, rise, buf_out, ep, ep); end
        end
    endtask

    task automatic test_random;
        int         per [6] = '{7, 13, 19, 26, 34, 45};
        int         m_cnt [6];
        logic [5:0] m_s1, m_s2, m_st, m_r, m_f;
        int         nc;
        logic       ns;
        reset = 1'b1; tick; tick;
        reset = 1'b0;
        m_s1 = '0; m_s2 = '0; m_st = '0;
        for (int c = 0; c < 6; c++) m_cnt[c] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < 6; c++) iv[c] = (((cyc + c * 11) / per[c]) % 2) == 1;
            ce = ($urandom_range(0, 7) != 0);
            m_r = '0; m_f = '0;
            for (int c = 0; c < 6; c++) begin
                if (ce) begin
                    nc = m_s2[c] ? ((m_cnt[c] == 15) ? 15 : m_cnt[c] + 1) : ((m_cnt[c] == 0) ? 0 : m_cnt[c] - 1);
                    ns = m_st[c] ? (nc > 3) : (nc >= 12);
                    m_r[c] = !m_st[c] && ns;
                    m_f[c] = m_st[c] && !ns;
                    m_cnt[c] = nc;
                    m_st[c] = ns;
                end
            end
            m_s2 = m_s1;
            m_s1 = iv;
            tick;
            checks++;
            if (buf_out !== m_st || rise !== m_r || fall !== m_f || ov !== ~m_st) begin
                errors++; $display("FAIL random[%0d]: buf %h rise %h fall %h want %h/%h/%h", cyc, buf_out, rise, fall, m_st, m_r, m_f);
            end
            checks++;
            if ((rise & fall) !== 6'h00) begin errors++; $display("FAIL random_both[%0d]: rise&fall %h want 00", cyc, rise & fall); end
        end
    endtask

    initial begin
        test_reset;
        test_all_rise;
        test_glitch;
        test_ce_slow;
        test_saturate;
        test_reset_mid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
